round_arb: RTL
==============

# round_arb

Round-robin scheduler that shares one combinational rounding stage among `N_REQ` vector-FPU result producers (adder, multiplier, MAC and divider lanes). It accepts normalized pre-round packets over per-requester valid/ready handshakes and drives the shared rounding stage from a registered operand stage. It captures the packed IEEE-754 single result in an output register and returns it with the originating requester index. Full throughput is one packet per cycle.

## Interface
Parameters:
- `N_REQ`, 4, number of requesters (2..8).
- `TAG_W`, 2, requester-index width; must equal ceil(log2(`N_REQ`)).

Ports:
- `clk`  in  1  single clock; all state on rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `flush`  in  1  synchronous pipeline flush, highest priority after reset.
- `req_valid`  in  `N_REQ`  per-requester packet valid.
- `req_ready`  out  `N_REQ`  per-requester accept; one-hot or zero.
- `req_data`  in  `41*N_REQ`  packet i at bits [41i+40:41i]. Field layout: {nj_mode[40], s_final[39], exp_norm[38:29], frac_inter_norm[28:2], denorm_m[1], zero_m[0]}.
- `rs_nj_mode`, `rs_s_final`  out  1 each  registered operands to the rounding stage.
- `rs_exp_norm`  out  10  registered operand to the rounding stage.
- `rs_frac_inter_norm`  out  27  registered operand to the rounding stage.
- `rs_denorm_m`, `rs_zero_m`  out  1 each  registered operands to the rounding stage.
- `rs_res`  in  32  combinational result returned from the rounding stage.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  downstream accept.
- `out_res`  out  32  rounded result.
- `out_tag`  out  `TAG_W`  index of the requester that issued the packet.
- `busy`  out  1  high when either stage A or stage B holds a valid entry.

## Operation
- Two register stages:
  - Stage A (`a_valid`, `a_tag`, operand regs) drives the `rs_*` outputs directly.
  - Stage B (`out_valid`, `out_res`, `out_tag`) captures `rs_res` and `a_tag`.
- Stall equations:
  - `b_adv = !out_valid | out_ready`.
  - `a_adv = !a_valid | b_adv`.
- Arbitration:
  - `ptr` (TAG_W) holds the last granted index.
  - Priority order is `ptr+1, ptr+2, ...`, wrapping modulo `N_REQ`.
  - `grant` is the first requester in that order with `req_valid` high.
  - `req_ready = grant & {N_REQ{a_adv & !flush}}`.
- Accept: when any `req_valid & req_ready` is high, stage A loads that packet, sets `a_tag` = its index and sets `a_valid`=1. `ptr` is updated to the index only on an accept.
- When `a_adv` is high and nothing is accepted, `a_valid` goes to 0. Operand regs hold their last value.
- When `b_adv` is high, stage B loads `out_valid<=a_valid`, and loads `out_res<=rs_res` and `out_tag<=a_tag` only if `a_valid`. Otherwise stage B holds.
- The arbiter never modifies result bits; rounding, exponent and special-case handling belong entirely to the rounding stage.
- `flush`: next edge clears `a_valid` and `out_valid` and sets `ptr` to `N_REQ-1`. No accept occurs in the flush cycle. Data regs keep their values.
- Reset values:
  - `a_valid`, `out_valid`, all `rs_*` regs, `out_res` and `out_tag` are 0.
  - `ptr` is `N_REQ-1`, so requester 0 is granted first.
  - `busy` is 0.
- Reset asserted mid-operation discards all in-flight packets with no result emitted.

## Timing
- Latency: a packet accepted at edge k drives `rs_*` during cycle k+1 and appears on `out_valid`/`out_res` after edge k+1. Result is visible 1 cycle after acceptance, 2 edges from the `req_valid` cycle.
- Throughput is 1 packet per cycle with `out_ready` held high. No bubble is inserted on requester switch.
- Backpressure: while `out_valid & !out_ready`, `out_res`/`out_tag` stay stable. A full stage A also blocks all `req_ready`. Capacity is 2 packets.
- `req_ready` is combinational from `req_valid`, `ptr`, `a_valid`, `out_valid`, `out_ready` and `flush`. Requesters must not make `req_valid` depend on `req_ready`.
- A requester holding `req_valid` is granted within `N_REQ` accepts.

## Test plan
- Single request: req 2 sends exp_norm=0, frac_inter_norm=27'h4000000, other fields 0. Required response: `out_valid` one cycle after accept, `out_res`=32'h3F800000, `out_tag`=2.
- Tie rounding path: frac_inter_norm={24'h800001,3'b100}, exp_norm=0. Required response: `out_res`=32'h3F800002, with operands passed bit-exact on `rs_*`.
- All four `req_valid` high for 8 cycles after reset, `out_ready`=1. Required response: grant order 0,1,2,3,0,1,2,3 and `out_tag` in the same order, back-to-back.
- `out_ready` low for 5 cycles with continuous requests. Required response: `out_res`/`out_tag` frozen, exactly 2 packets buffered, all `req_ready`=0. After release, results drain in order with no loss or duplication.
- `flush` asserted with both stages valid. Required response: next cycle `out_valid`=0, `busy`=0, no `req_ready` in the flush cycle, and req 0 granted first afterward.
- `rst_n` pulsed low mid-stream. Required response: all outputs at reset values immediately, asynchronously, and no stale result emitted after release.

Source files
------------

// File: rtl/round_arb.sv
// Round-robin front end for a shared combinational rounding stage.
// Stage A registers the granted packet onto rs_*, stage B captures rs_res with its requester tag.
module round_arb #(
  parameter int N_REQ = 4,
  parameter int TAG_W = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic [N_REQ-1:0]     req_valid,
  output logic [N_REQ-1:0]     req_ready,
  input  logic [41*N_REQ-1:0]  req_data,
  output logic                 rs_nj_mode,
  output logic                 rs_s_final,
  output logic [9:0]           rs_exp_norm,
  output logic [26:0]          rs_frac_inter_norm,
  output logic                 rs_denorm_m,
  output logic                 rs_zero_m,
  input  logic [31:0]          rs_res,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          out_res,
  output logic [TAG_W-1:0]     out_tag,
  output logic                 busy
);

  logic             a_valid;
  logic [TAG_W-1:0] a_tag;
  logic [TAG_W-1:0] ptr;
  logic             b_adv;
  logic             a_adv;
  logic [N_REQ-1:0] grant;
  logic [TAG_W-1:0] grant_idx;
  logic             found;
  logic             accept;
  logic [40:0]      pkt;

  assign b_adv = !out_valid || out_ready;
  assign a_adv = !a_valid || b_adv;

  // Search starts one past the last winner, so the last winner has lowest priority.
  // NOTE: every always_comb output gets a default first; otherwise a path that skips it infers a latch.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    for (int off = 1; off <= N_REQ; off++) begin
      int idx;
      idx = (int'(ptr) + off) % N_REQ;
      if (!found && req_valid[idx]) begin
        grant[idx] = 1'b1;
        grant_idx  = TAG_W'(idx);
        found      = 1'b1;
      end
    end
  end

  assign req_ready = grant & {N_REQ{a_adv && !flush}};
  assign accept    = found && a_adv && !flush;
  assign pkt       = req_data[41*int'(grant_idx) +: 41];
  assign busy      = a_valid || out_valid;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_valid            <= 1'b0;
      a_tag              <= '0;
      ptr                <= TAG_W'(N_REQ - 1);
      rs_nj_mode         <= 1'b0;
      rs_s_final         <= 1'b0;
      rs_exp_norm        <= '0;
      rs_frac_inter_norm <= '0;
      rs_denorm_m        <= 1'b0;
      rs_zero_m          <= 1'b0;
      out_valid          <= 1'b0;
      out_res            <= '0;
      out_tag            <= '0;
    end else if (flush) begin
      // Valids drop and the pointer rewinds; data registers keep their contents.
      a_valid   <= 1'b0;
      out_valid <= 1'b0;
      ptr       <= TAG_W'(N_REQ - 1);
    end else begin
      if (accept) begin
        a_valid            <= 1'b1;
        a_tag              <= grant_idx;
        ptr                <= grant_idx;
        rs_nj_mode         <= pkt[40];
        rs_s_final         <= pkt[39];
        rs_exp_norm        <= pkt[38:29];
        rs_frac_inter_norm <= pkt[28:2];
        rs_denorm_m        <= pkt[1];
        rs_zero_m          <= pkt[0];
      end else if (a_adv) begin
        a_valid <= 1'b0;
      end
      if (b_adv) begin
        out_valid <= a_valid;
        if (a_valid) begin
          out_res <= rs_res;
          out_tag <= a_tag;
        end
      end
    end
  end

endmodule
